// File: rtl/wb_gpio_ctrl.sv
// Wishbone B3 classic GPIO slave: per-bit direction, synchronised inputs, atomic set/clear
// and edge-triggered interrupts. One-cycle registered acknowledge, no wait states.
module wb_gpio_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  localparam logic [2:0] AdrOut  = 3'd0;
  localparam logic [2:0] AdrDir  = 3'd1;
  localparam logic [2:0] AdrIn   = 3'd2;
  localparam logic [2:0] AdrEn   = 3'd3;
  localparam logic [2:0] AdrEdge = 3'd4;
  localparam logic [2:0] AdrStat = 3'd5;
  localparam logic [2:0] AdrSet  = 3'd6;
  localparam logic [2:0] AdrClr  = 3'd7;

  localparam int unsigned LastStage = SYNC_STAGES - 1;

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             irq_q;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] irq_edge_q, irq_edge_d;
  logic [WIDTH-1:0] irq_status_q, irq_status_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  logic             req;
  logic             wr;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [31:0]      rd;

  // A request is only accepted while no ack is outstanding, giving ack/idle/ack on held strobe.
  assign req = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr  = req & wb_we_i;

  assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wdata     = wb_dat_i[WIDTH-1:0] & wmask;

  assign sync = sync_q[LastStage];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;
  assign ev   = (irq_edge_q & rise) | (~irq_edge_q & fall);

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    irq_edge_d = irq_edge_q;
    w1c        = '0;
    if (wr) begin
      unique case (wb_adr_i)
        AdrOut:  data_out_d = (data_out_q & ~wmask) | wdata;
        AdrDir:  dir_d      = (dir_q & ~wmask) | wdata;
        AdrIn:   ;
        AdrEn:   irq_en_d   = (irq_en_q & ~wmask) | wdata;
        AdrEdge: irq_edge_d = (irq_edge_q & ~wmask) | wdata;
        AdrStat: w1c        = wdata;
        AdrSet:  data_out_d = data_out_q | wdata;
        AdrClr:  data_out_d = data_out_q & ~wdata;
      endcase
    end
    // A fresh edge wins over a simultaneous clear of the same bit.
    irq_status_d = (irq_status_q & ~w1c) | ev;
  end

  always_comb begin
    rd = '0;
    case (wb_adr_i)
      AdrOut:  rd[WIDTH-1:0] = data_out_q;
      AdrDir:  rd[WIDTH-1:0] = dir_q;
      AdrIn:   rd[WIDTH-1:0] = sync;
      AdrEn:   rd[WIDTH-1:0] = irq_en_q;
      AdrEdge: rd[WIDTH-1:0] = irq_edge_q;
      AdrStat: rd[WIDTH-1:0] = irq_status_q;
      default: rd = '0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      irq_q        <= 1'b0;
      data_out_q   <= OUT_RESET[WIDTH-1:0];
      dir_q        <= DIR_RESET[WIDTH-1:0];
      irq_en_q     <= '0;
      irq_edge_q   <= '0;
      irq_status_q <= '0;
      prev_q       <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      ack_q <= req;
      if (req) begin
        dat_q <= rd;
      end
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      irq_edge_q   <= irq_edge_d;
      irq_status_q <= irq_status_d;
      prev_q       <= sync;
      irq_q        <= |(irq_status_q & irq_en_q);
      sync_q[0]    <= gpio_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;
  assign gpio_o    = data_out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;

  // Burst qualifiers are accepted but every access is treated as a classic single transfer.
  logic unused;
  assign unused = ^{wb_cti_i, wb_bte_i, wb_dat_i, lane_mask};

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Scoreboard bench for wb_gpio_ctrl: a 32-bit instance checked against a register-level model
// with random traffic and pin activity, plus a 5-bit instance for width masking and reset.
module tb_wb_gpio_ctrl;

  localparam int unsigned Sync = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        cyc5;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o, dat5_o;
  logic        ack, ack5, err, err5, rty, rty5;
  logic [31:0] gpio_i, gpio_o, gpio_oe;
  logic [4:0]  gpio5_i, gpio5_o, gpio5_oe;
  logic        irq, irq5;

  wb_gpio_ctrl #(
    .WIDTH(32), .SYNC_STAGES(Sync), .OUT_RESET(32'hA5), .DIR_RESET(32'hFF)
  ) u_dut (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe), .irq_o(irq)
  );

  wb_gpio_ctrl #(
    .WIDTH(5), .SYNC_STAGES(3), .OUT_RESET(32'h15), .DIR_RESET(32'h0)
  ) u_dut5 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc5), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat5_o), .wb_ack_o(ack5), .wb_err_o(err5), .wb_rty_o(rty5),
    .gpio_i(gpio5_i), .gpio_o(gpio5_o), .gpio_oe_o(gpio5_oe), .irq_o(irq5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic [31:0] exp;
  } exp_t;

  exp_t q_main[$];
  exp_t q5[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Register-level reference model of the 32-bit instance.
  logic [31:0] m_out, m_dir, m_en, m_edge, m_stat, m_pins;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every acknowledge consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (ack) begin
      if (q_main.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        e = q_main.pop_front();
        if (e.chk) check("rdata", dat_o, e.exp);
      end
    end
    if (ack5) begin
      if (q5.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_ack5: got ack=1 expected no ack at %0t", $time);
      end else begin
        e = q5.pop_front();
        if (e.chk) check("rdata5", dat5_o, e.exp);
      end
    end
  end

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Single classic access; entered and left just after a rising edge.
  task automatic bus(input bit t5, input bit w, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp_rd, input logic [31:0] exp_out);
    exp_t e;
    e.chk = !w;
    e.exp = exp_rd;
    if (t5) q5.push_back(e);
    else q_main.push_back(e);
    adr = a; dat_i = d; sel = s; we = w; stb = 1'b1;
    if (t5) cyc5 = 1'b1;
    else cyc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(t5 ? "ack_latency5" : "ack_latency", t5 ? 32'(ack5) : 32'(ack), 32'd1);
    if (w) check(t5 ? "gpio5_at_ack" : "gpio_at_ack", t5 ? {27'b0, gpio5_o} : gpio_o, exp_out);
    @(posedge clk);
    #1;
    cyc = 1'b0; cyc5 = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic mwrite(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = d & lanes(s);
    case (a)
      3'd0: m_out  = (m_out & ~lanes(s)) | m;
      3'd1: m_dir  = (m_dir & ~lanes(s)) | m;
      3'd3: m_en   = (m_en & ~lanes(s)) | m;
      3'd4: m_edge = (m_edge & ~lanes(s)) | m;
      3'd5: m_stat = m_stat & ~m;
      3'd6: m_out  = m_out | m;
      3'd7: m_out  = m_out & ~m;
      default: ;
    endcase
    bus(1'b0, 1'b1, a, d, s, 32'h0, m_out);
  endtask

  task automatic mread(input logic [2:0] a);
    logic [31:0] e;
    case (a)
      3'd0: e = m_out;
      3'd1: e = m_dir;
      3'd2: e = m_pins;
      3'd3: e = m_en;
      3'd4: e = m_edge;
      3'd5: e = m_stat;
      default: e = 32'h0;
    endcase
    bus(1'b0, 1'b0, a, $urandom, 4'($urandom_range(0, 15)), e, m_out);
  endtask

  // Returns the interrupt events a pin change will produce once synchronised.
  function automatic logic [31:0] pin_events(input logic [31:0] old_v, input logic [31:0] new_v);
    return (m_edge & new_v & ~old_v) | (~m_edge & ~new_v & old_v);
  endfunction

  task automatic pins(input logic [31:0] nv);
    m_stat = m_stat | pin_events(m_pins, nv);
    m_pins = nv;
    gpio_i = nv;
    repeat (Sync + 3) @(posedge clk);
    #1;
  endtask

  task automatic check_irq();
    check("irq_o", 32'(irq), 32'(|(m_stat & m_en)));
  endtask

  initial begin
    logic [31:0] ev;
    rst = 1'b1; cyc = 1'b0; cyc5 = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    sel = '0; cti = 3'b111; bte = 2'b01; gpio_i = '0; gpio5_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gpio_o", gpio_o, 32'hA5);
    check("rst_gpio_oe", gpio_oe, 32'hFF);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    check("rst_gpio5_o", {27'b0, gpio5_o}, 32'h15);
    check("err_rty", {30'b0, err, rty}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_out = 32'hA5; m_dir = 32'hFF; m_en = '0; m_edge = '0; m_stat = '0; m_pins = '0;

    // Byte-lane gated write and readback.
    mwrite(3'd0, 32'h12345678, 4'b0011);
    mread(3'd0);
    check("partial_write", m_out, 32'h00005678);

    // Atomic set / clear.
    mwrite(3'd0, 32'hF0, 4'hF);
    mwrite(3'd6, 32'h0F, 4'hF);
    mwrite(3'd7, 32'h81, 4'hF);
    check("set_clr_model", m_out, 32'h7E);
    mread(3'd6);
    mread(3'd7);

    // Held strobe: ack, idle, ack, idle.
    q_main.push_back('{chk: 1'b1, exp: m_out});
    q_main.push_back('{chk: 1'b1, exp: m_out});
    adr = 3'd0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_ack", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    #1;

    // Rising-edge interrupt on bit 3, cycle-exact irq latency.
    mwrite(3'd3, 32'h8, 4'hF);
    mwrite(3'd4, 32'h8, 4'hF);
    m_stat = m_stat | pin_events(m_pins, 32'h8);
    m_pins = 32'h8;
    gpio_i = 32'h8;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k >= 3) check("irq_latency", 32'(irq), (k == 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    mread(3'd5);
    mwrite(3'd5, 32'h8, 4'hF);
    check_irq();
    pins(32'h0);
    mread(3'd5);
    check_irq();

    // Clear of bit 3 lands on the same edge as a new rising edge on bit 3.
    ev = pin_events(m_pins, 32'h8);
    m_pins = 32'h8;
    gpio_i = 32'h8;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_stat = (m_stat & ~32'h8) | ev;
    bus(1'b0, 1'b1, 3'd5, 32'h8, 4'hF, 32'h0, m_out);
    mread(3'd5);
    check_irq();
    pins(32'h0);
    mwrite(3'd5, 32'hFFFF_FFFF, 4'hF);

    // Random register traffic interleaved with random pin activity.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) pins($urandom);
      if ($urandom_range(0, 1) == 0) begin
        mwrite(3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      end else begin
        mread(3'($urandom_range(0, 7)));
      end
      check("gpio_o", gpio_o, m_out);
      check("gpio_oe", gpio_oe, m_dir);
      check_irq();
    end

    // Narrow instance: bits above WIDTH read 0 and ignore writes.
    bus(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h15);
    check("gpio5_oe", {27'b0, gpio5_oe}, 32'h1F);
    bus(1'b1, 1'b0, 3'd1, 32'h0, 4'h0, 32'h1F, 32'h15);
    bus(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'b0000, 32'h0, 32'h15);
    bus(1'b1, 1'b1, 3'd6, 32'h0000_000A, 4'b0001, 32'h0, 32'h1F);
    bus(1'b1, 1'b1, 3'd7, 32'hFFFF_FFF0, 4'hF, 32'h0, 32'h0F);
    bus(1'b1, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0F, 32'h0F);
    bus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 32'h0F);

    // Reset on the request edge: no ack and the write is dropped.
    rst = 1'b1; cyc5 = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd0; dat_i = 32'h0; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ack5", 32'(ack5), 32'd0);
    check("rst_mid_gpio5", {27'b0, gpio5_o}, 32'h15);
    check("rst_mid_gpio_o", gpio_o, 32'hA5);
    check("rst_mid_irq", 32'(irq), 32'd0);
    cyc5 = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    check("main_queue_drained", 32'(q_main.size()), 32'd0);
    check("q5_drained", 32'(q5.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
